// File: rtl/crc16_stream_pkg.sv
// Shared types and constants for the CRC-16 (poly 0x1021) byte-stream sequencer.
package crc16_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [15:0] CRC16_POLY     = 16'h1021;
  localparam logic [15:0] CRC16_INIT_VAL = 16'hFFFF;
  localparam logic [15:0] CRC16_XOR_OUT  = 16'h0000;

endpackage : crc16_stream_pkg

// File: rtl/crc16_1021.sv
// Combinational CRC-16 (poly 0x1021) step over one nibble; data_i[3] is the first serial bit.
module crc16_1021
  import crc16_stream_pkg::*;
(
  input  logic [3:0]  data_i,
  input  logic [15:0] crc_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_v;
  logic        fb;

  always_comb begin
    crc_v = crc_i;
    fb    = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      fb    = crc_v[15] ^ data_i[i];
      crc_v = {crc_v[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
    crc_o = crc_v;
  end

endmodule : crc16_1021

// File: rtl/crc16_stream_ctrl.sv
// Byte-stream sequencer feeding the nibble CRC datapath, high nibble first, one result per frame.
// Optional byte counter output len_o is enabled by defining CRC16_STREAM_CTRL_LEN_EN.
module crc16_stream_ctrl
  import crc16_stream_pkg::*;
#(
  parameter logic [15:0] INIT_VAL = CRC16_INIT_VAL,
  parameter logic [15:0] XOR_OUT  = CRC16_XOR_OUT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        dat_valid_i,
  output logic        dat_ready_o,
  input  logic [7:0]  dat_i,
  input  logic        dat_last_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_o,
  output logic        busy_o
`ifdef CRC16_STREAM_CTRL_LEN_EN
  ,
  output logic [15:0] len_o
`endif
);

  state_e      state_q, state_d;
  logic [15:0] crc_q, crc_d, crc_nxt;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic [3:0]  nibble;
  logic        dat_acc;

  assign nibble = (state_q == ST_HI) ? byte_q[7:4] : byte_q[3:0];

  crc16_1021 u_crc (
    .data_i (nibble),
    .crc_i  (crc_q),
    .crc_o  (crc_nxt)
  );

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    byte_d      = byte_q;
    last_d      = last_q;
    dat_ready_o = 1'b0;
    res_valid_o = 1'b0;
    dat_acc     = 1'b0;

    if (clr_i) begin
      state_d = ST_IDLE;
      crc_d   = INIT_VAL;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          dat_ready_o = 1'b1;
          if (dat_valid_i) begin
            dat_acc = 1'b1;
            state_d = ST_HI;
          end
        end
        ST_HI: begin
          crc_d   = crc_nxt;
          state_d = ST_LO;
        end
        ST_LO: begin
          crc_d       = crc_nxt;
          dat_ready_o = !last_q;
          if (last_q) begin
            state_d = ST_DONE;
          end else if (dat_valid_i) begin
            dat_acc = 1'b1;
            state_d = ST_HI;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          res_valid_o = 1'b1;
          if (res_ready_i) begin
            crc_d   = INIT_VAL;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (dat_acc) begin
      byte_d = dat_i;
      last_d = dat_last_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      crc_q   <= INIT_VAL;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
    end
  end

  assign res_o  = crc_q ^ XOR_OUT;
  assign busy_o = (state_q != ST_IDLE);

`ifdef CRC16_STREAM_CTRL_LEN_EN
  logic [15:0] len_q, len_d;

  always_comb begin
    len_d = len_q;
    if (clr_i || (res_valid_o && res_ready_i)) begin
      len_d = 16'h0000;
    end else if (dat_acc && (len_q != 16'hFFFF)) begin
      len_d = len_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      len_q <= 16'h0000;
    end else begin
      len_q <= len_d;
    end
  end

  assign len_o = len_q;
`endif

endmodule : crc16_stream_ctrl
